// File: rtl/pulse_stretcher.sv
// pulse_stretcher: turns 1-cycle events into fixed-width high windows separated by a guaranteed low gap.
// Events that arrive while a window is in progress are queued in a saturating counter; dropped events raise overflow.
module pulse_stretcher #(
    parameter int HIGH_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int QUEUE_MAX   = 3,
    localparam int PW = $clog2(QUEUE_MAX + 1),
    localparam int CW = $clog2((HIGH_CYCLES > GAP_CYCLES ? HIGH_CYCLES : GAP_CYCLES) + 1)
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          i_pulse_in,
    output logic          o_level_out,
    output logic          o_busy,
    output logic [PW-1:0] o_pending,
    output logic          o_overflow
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HIGH = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [1:0]    r_state, w_state;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [PW-1:0] r_pending, w_pending;
    logic          r_level, w_level;
    logic          r_overflow;
    logic          w_cnt_zero, w_gap_end, w_consume, w_direct, w_start;
    logic          w_queue_req, w_drop, w_inc;

    assign w_cnt_zero  = r_cnt == '0;
    assign w_gap_end   = r_state == S_GAP && w_cnt_zero;
    assign w_consume   = w_gap_end && r_pending != '0;
    assign w_direct    = i_pulse_in && (r_state == S_IDLE || (w_gap_end && r_pending == '0));
    assign w_start     = w_direct || w_consume;
    assign w_queue_req = i_pulse_in && !w_direct;
    // A consume on the same cycle frees a slot, so a full queue still takes the request.
    assign w_drop      = w_queue_req && r_pending == PW'(QUEUE_MAX) && !w_consume;
    assign w_inc       = w_queue_req && !w_drop;
    assign w_pending   = w_inc && !w_consume ? r_pending + PW'(1) :
                         !w_inc && w_consume ? r_pending - PW'(1) : r_pending;

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_level = r_level;
        if (w_start) begin
            w_state = S_HIGH;
            w_cnt   = CW'(HIGH_CYCLES - 1);
            w_level = 1'b1;
        end else if (r_state == S_HIGH) begin
            w_state = w_cnt_zero ? S_GAP : S_HIGH;
            w_cnt   = w_cnt_zero ? CW'(GAP_CYCLES - 1) : r_cnt - CW'(1);
            w_level = !w_cnt_zero;
        end else if (r_state == S_GAP) begin
            w_state = w_cnt_zero ? S_IDLE : S_GAP;
            w_cnt   = w_cnt_zero ? '0 : r_cnt - CW'(1);
            w_level = 1'b0;
        end else begin
            w_state = S_IDLE;
            w_cnt   = '0;
            w_level = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_level    <= 1'b0;
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_level    <= w_level;
            r_pending  <= w_pending;
            r_overflow <= w_drop;
        end
    end

    assign o_level_out = r_level;
    assign o_busy      = r_state != S_IDLE;
    assign o_pending   = r_pending;
    assign o_overflow  = r_overflow;
endmodule

// File: doc/pulse_stretcher.md
# pulse_stretcher

Converts single-cycle event pulses into clean, fixed-width level windows separated by a guaranteed low gap. One rising edge on `level_out` per accepted input pulse, so any downstream edge detector (2-FF rising-edge stage) recovers exactly one pulse per event. It sits on the output side of the button/event path and drives LEDs, strobes and slow-clocked consumers that cannot see 1-cycle pulses. Bursts are absorbed by a saturating pending counter, and lost events are flagged.

## Interface
- `HIGH_CYCLES`, default 4: width of each high window in clk cycles; must be ≥1.
- `GAP_CYCLES`, default 2: minimum low cycles between windows; must be ≥1.
- `QUEUE_MAX`, default 3: maximum pending (queued) events; must be ≥1.
- `clk`, in, 1: clock, rising edge.
- `nrst`, in, 1: reset, asynchronous, active-low.
- `pulse_in`, in, 1: event request. Every cycle it is sampled high counts as one event.
- `level_out`, out, 1: registered stretched level.
- `busy`, out, 1: high while state ≠ IDLE. Decoded from the state register only.
- `pending`, out, $clog2(QUEUE_MAX+1): registered count of queued events.
- `overflow`, out, 1: registered one-cycle pulse, high when an event was dropped.

## Operation
- States:
  - IDLE
  - HIGH: `level_out`=1
  - GAP: `level_out`=0
- Down-counter `cnt`, width $clog2(max(HIGH_CYCLES,GAP_CYCLES)+1).
- IDLE, `pulse_in`=1: go to HIGH, `cnt`←HIGH_CYCLES−1, `level_out`←1. This is a direct accept; `pending` is unchanged.
- HIGH:
  - `cnt`≠0: decrement.
  - `cnt`==0: go to GAP, `cnt`←GAP_CYCLES−1, `level_out`←0.
- GAP, `cnt`≠0: decrement.
- GAP, `cnt`==0 (gap-end cycle):
  - `pending`>0: go to HIGH, `cnt`←HIGH_CYCLES−1, `pending` decrements (consume).
  - else `pulse_in`=1: go to HIGH as a direct accept.
  - else: go to IDLE.
- `pulse_in`=1 that is neither a direct accept nor an idle accept is a queue request.
  - Queue request with `pending`<QUEUE_MAX, or on a consume cycle: `pending` increments. Net effect on a consume cycle is `pending` unchanged.
  - Queue request with `pending`==QUEUE_MAX and no consume that cycle: event dropped, `overflow`←1 for the next cycle only, `pending` stays QUEUE_MAX.
- `pending` never wraps: no increment past QUEUE_MAX, no decrement below 0.
- `pulse_in` held high N cycles counts as N events. Upstream normally feeds 1-cycle pulses.

## Timing
- Reset (async, `nrst`=0): state IDLE, `cnt`=0, `level_out`=0, `busy`=0, `pending`=0, `overflow`=0. Outputs go low immediately, without waiting for clk.
- Reset mid-window or mid-queue discards all state. The first accepted pulse after release behaves as from IDLE.
- Latency: `pulse_in` sampled at edge t (IDLE) gives `level_out` high at t+1 … t+HIGH_CYCLES.
- Gap: low cycles t+HIGH_CYCLES+1 … t+HIGH_CYCLES+GAP_CYCLES.
- Queued window: starts at t+HIGH_CYCLES+GAP_CYCLES+1.
- Period for back-to-back windows: exactly HIGH_CYCLES+GAP_CYCLES.
- `busy` is high for HIGH_CYCLES+GAP_CYCLES cycles per window, without dropping between chained windows.
- `pending` and `overflow` update one cycle after the sampling edge.

## Test plan
- Single pulse (defaults), `pulse_in` high at cycle 10:
  - `level_out` high cycles 11–14, low from 15.
  - `busy` high 11–16, low at 17.
  - `pending`=0, `overflow`=0 throughout.
- Burst, pulses at cycles 10, 11, 12:
  - `pending`=1 at 12, 2 at 13, 1 at 17, 0 at 23.
  - Windows at 11–14, 17–20, 23–26, with gaps 15–16 and 21–22.
  - `busy` continuous 11–28.
- Overflow, `pulse_in` high cycles 10–14:
  - `pending` reaches 3 at 14.
  - `overflow` high in cycle 15 only; `pending` stays 3.
  - Windows at 11, 17, 23, 29, each 4 cycles wide.
- Simultaneous consume and request, `pending`=3, pulse on the gap-end cycle:
  - `pending` stays 3.
  - `overflow` stays 0.
  - Next window starts the following cycle.
- Async reset during HIGH, `nrst`=0 at cycle 12.5:
  - `level_out`, `busy`, `pending` and `overflow` are 0 before the next edge.
  - After release, a pulse at cycle 20 gives a window at 21–24.
- Parameter corner, HIGH_CYCLES=1, GAP_CYCLES=1, QUEUE_MAX=1, pulses at 10 and 11:
  - `level_out` high 11 and 13, low 12 and 14.
  - `pending` 1 at 12, 0 at 13.
